// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: assembles 32-bit little-endian words from a byte memory, sharing the port with a program loader.
// Optional INST_FETCH_RANGE_CHECK_EN adds a sticky fetch_err for a pc outside the memory.
module inst_fetch_ctrl #(
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  localparam int         AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_code,
`ifdef INST_FETCH_RANGE_CHECK_EN
  output logic          fetch_err,
`endif
  output logic [31:0]   inst_pc
);
  typedef enum logic {FETCH, VALID} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [31:0] pc, pc_n, code_n, target;
  logic oor, stall;
  assign target = redirect_pc & ~32'd3;
  assign stall = state == FETCH && cnt == 2'd0 && oor;
`ifdef INST_FETCH_RANGE_CHECK_EN
  assign oor = pc >= 32'(MEM_BYTES);
  always_ff @(posedge clk)
    if (reset) fetch_err <= 1'b0;
    else if (redirect) fetch_err <= fetch_err & (target >= 32'(MEM_BYTES));
    else if (stall) fetch_err <= 1'b1;
`else
  assign oor = 1'b0;
`endif
  always_comb begin
    ld_ready = ld_valid & ~reset;
    mem_we = ld_ready;
    mem_wdata = ld_ready ? ld_data : 8'h00;
    mem_addr = ld_ready ? ld_addr : pc[AW-1:0] + AW'(cnt);
    inst_valid = state == VALID;
    inst_pc = pc;
    state_n = state;
    cnt_n = cnt;
    pc_n = pc;
    code_n = inst_code;
    // a loader cycle steals the port, so the word restarts rather than mixing old and new bytes
    if (state == FETCH && !stall) begin
      if (ld_ready) cnt_n = 2'd0;
      else begin
        code_n[{cnt, 3'b000} +: 8] = mem_rdata;
        cnt_n = cnt + 2'd1;
        state_n = cnt == 2'd3 ? VALID : FETCH;
      end
    end
    if (inst_valid && inst_ready) begin
      pc_n = pc + 32'd4;
      state_n = FETCH;
      cnt_n = 2'd0;
    end
    if (redirect) begin
      pc_n = target;
      state_n = FETCH;
      cnt_n = 2'd0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      cnt <= 2'd0;
      pc <= PC_RESET;
      inst_code <= 32'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc <= pc_n;
      inst_code <= code_n;
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: scoreboard bench; a word-level model predicts each delivered word and its timing.
module tb_inst_fetch_ctrl;
  localparam int MEM = 32;
  localparam int AW = 5;
  localparam logic [31:0] PRST = 32'h0;
`ifdef INST_FETCH_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, ld_valid = 1'b0, redirect = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] ld_addr = '0, mem_addr;
  logic [7:0] ld_data = '0, mem_rdata, mem_wdata;
  logic [31:0] redirect_pc = '0, inst_code, inst_pc;
  logic mem_we, ld_ready, inst_valid;
`ifdef INST_FETCH_RANGE_CHECK_EN
  logic fetch_err;
`endif
  logic [7:0] ram [MEM];
  logic [7:0] ref_mem [MEM];
  logic [31:0] m_pc = PRST;
  int m_run = 0;
  bit m_valid = 1'b0, m_rst = 1'b1, m_err = 1'b0, was_valid = 1'b0;
  logic [63:0] exp_q [$];
  logic [63:0] cur = '0;
  int vectors = 0, miscompares = 0;

  inst_fetch_ctrl #(.MEM_BYTES(MEM), .PC_RESET(PRST)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_code(inst_code),
`ifdef INST_FETCH_RANGE_CHECK_EN
    .fetch_err(fetch_err),
`endif
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w0 = 32'h0094_0333, w1 = 32'h4139_03B3;
    if (i < 4) return w0[8*i +: 8];
    if (i < 8) return w1[8*(i-4) +: 8];
    return 8'(i * 37 + 11);
  endfunction

  // environment memory the DUT talks to
  assign mem_rdata = ram[mem_addr];
  initial begin
    for (int i = 0; i < MEM; i++) ram[i] = init_byte(i);
    forever @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [31:0] w = '0;
    for (int i = 3; i >= 0; i--) w = {w[23:0], ref_mem[AW'(pc + 32'(i))]};
    return w;
  endfunction

  // word-level model: a word is ready after four port cycles in a row free of loader writes
  task automatic model_step();
    m_rst = reset;
    if (reset) begin
      m_pc = PRST; m_valid = 1'b0; m_run = 0; m_err = 1'b0;
    end else begin
      if (ld_valid) ref_mem[ld_addr] = ld_data;
      if (redirect) begin
        m_pc = redirect_pc & ~32'd3; m_valid = 1'b0; m_run = 0;
        m_err = m_err && m_pc >= MEM;
      end else if (m_valid) begin
        if (inst_ready) begin m_pc = m_pc + 32'd4; m_valid = 1'b0; end
      end else if (RC && m_run == 0 && m_pc >= MEM) m_err = 1'b1;
      else if (ld_valid) m_run = 0;
      else if (++m_run == 4) begin
        m_run = 0; m_valid = 1'b1;
        exp_q.push_back({m_pc, ref_word(m_pc)});
      end
    end
  endtask

  // monitor: checks the DUT a little after each active edge
  always @(posedge clk) begin
    #2;
    chk("ld_ready", 64'(ld_ready), 64'(ld_valid & ~reset));
    chk("mem_we", 64'(mem_we), 64'(ld_valid & ~reset));
    chk("mem_wdata", 64'(mem_wdata), 64'((ld_valid && !reset) ? ld_data : 8'h00));
    if (ld_valid && !reset) chk("mem_addr_ld", 64'(mem_addr), 64'(ld_addr));
    else if (!m_valid && !(RC && m_pc >= MEM)) chk("mem_addr_fetch", 64'(mem_addr), 64'(AW'(m_pc + 32'(m_run))));
    chk("inst_valid", 64'(inst_valid), 64'(m_valid));
`ifdef INST_FETCH_RANGE_CHECK_EN
    chk("fetch_err", 64'(fetch_err), 64'(m_err));
`endif
    if (m_rst) begin
      chk("rst_code", 64'(inst_code), 64'h0);
      chk("rst_pc", 64'(inst_pc), 64'(PRST));
    end
    if (inst_valid && !was_valid) begin
      if (exp_q.size() == 0) chk("word_expected", 64'h0, 64'h1);
      else cur = exp_q.pop_front();
    end
    if (inst_valid) begin
      chk("inst_pc", 64'(inst_pc), 64'(cur[63:32]));
      chk("inst_code", 64'(inst_code), 64'(cur[31:0]));
    end
    was_valid = inst_valid;
  end

  task automatic step(input bit r, input bit lv, input logic [AW-1:0] la, input logic [7:0] ld,
                      input bit rd, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    reset = r; ld_valid = lv; ld_addr = la; ld_data = ld;
    redirect = rd; redirect_pc = rp; inst_ready = rdy;
    model_step();
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 1'b0, '0, 8'h00, 1'b0, 32'h0, rdy);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 12 && !m_valid; i++) idle(1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
    repeat (2) step(1'b1, 1'b0, '0, 8'h00, 1'b0, 32'h0, 1'b0);
    idle(10, 1'b1);
    wait_valid(); idle(10, 1'b0); idle(6, 1'b1);
    step(1'b0, 1'b0, '0, 8'h00, 1'b1, 32'h0, 1'b0); idle(2, 1'b0);
    step(1'b0, 1'b1, 5'd1, 8'hAA, 1'b0, 32'h0, 1'b0);
    wait_valid(); idle(1, 1'b1);
    wait_valid(); step(1'b0, 1'b0, '0, 8'h00, 1'b1, 32'h1E, 1'b1);
    wait_valid(); idle(6, 1'b1);
    step(1'b0, 1'b0, '0, 8'h00, 1'b1, 32'h0, 1'b0); idle(2, 1'b0);
    step(1'b1, 1'b1, 5'd3, 8'h55, 1'b1, 32'h8, 1'b1);
    idle(6, 1'b1);
    repeat (800)
      step(1'($urandom_range(99) == 0), 1'($urandom_range(5) == 0), AW'($urandom), 8'($urandom),
           1'($urandom_range(19) == 0), 32'($urandom_range(2 * MEM - 1)), 1'($urandom_range(1)));
    idle(8, 1'b1);
    @(posedge clk); #4;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
